// File: rtl/micro_sequencer.sv
// ============================================================================
//  Module      : micro_sequencer
//  Description : Microprogrammed controller for the ALU/register-bank datapath
//                with a writable control store and n/z conditional branching.
//                Optional macro SINGLE_STEP_EN adds a 'step' input that holds
//                EXEC until step=1.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module micro_sequencer #(
    parameter int ADDR_W = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       start_addr,
    input  logic                    ucode_we,
    input  logic [ADDR_W-1:0]       ucode_addr,
    input  logic [24+2*ADDR_W-1:0]  ucode_wdata,
    input  logic                    n,
    input  logic                    z,
`ifdef SINGLE_STEP_EN
    input  logic                    step,
`endif
    output logic [7:0]              alu_shifter_opcode,
    output logic [8:0]              c_select,
    output logic [3:0]              b_select,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_W-1:0]       upc
);

    localparam int UW    = 24 + 2*ADDR_W;
    localparam int DEPTH = 2**ADDR_W;
    localparam int SEQ_W = UW - 21;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_upc;
    logic [SEQ_W-1:0]    r_seq;
    logic [7:0]          r_alu_op;
    logic [8:0]          r_c_sel;
    logic [3:0]          r_b_sel;
    logic                r_done;
    logic [UW-1:0]       r_store [DEPTH];

    logic [UW-1:0]       w_rd;
    logic [1:0]          w_cond;
    logic                w_halt;
    logic [ADDR_W-1:0]   w_next;
    logic [ADDR_W-1:0]   w_branch;
    logic                w_taken;
    logic                w_advance;

    // Sequencing fields of the word in EXEC; datapath fields live in the output regs.
    assign w_rd     = r_store[r_upc];
    assign w_cond   = r_seq[1:0];
    assign w_halt   = r_seq[2];
    assign w_next   = r_seq[2+ADDR_W:3];
    assign w_branch = r_seq[SEQ_W-1:3+ADDR_W];
    assign w_taken  = (w_cond == 2'b11) | ((w_cond == 2'b01) & n) | ((w_cond == 2'b10) & z);

`ifdef SINGLE_STEP_EN
    assign w_advance = step;
`else
    assign w_advance = 1'b1;
`endif

    // Control store is not reset; writes are accepted only while idle.
    always_ff @(posedge clock) begin
        if (!reset && r_state == S_IDLE && ucode_we) begin
            r_store[ucode_addr] <= ucode_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_upc    <= '0;
            r_seq    <= '0;
            r_alu_op <= '0;
            r_c_sel  <= '0;
            r_b_sel  <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_upc   <= start_addr;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_seq    <= w_rd[UW-1:21];
                    r_alu_op <= w_rd[7:0];
                    r_c_sel  <= w_rd[16:8];
                    r_b_sel  <= w_rd[20:17];
                    r_state  <= S_EXEC;
                end
                S_EXEC: begin
                    if (w_advance) begin
                        r_alu_op <= '0;
                        r_c_sel  <= '0;
                        r_b_sel  <= '0;
                        if (w_halt) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_upc   <= w_taken ? w_branch : w_next;
                            r_state <= S_FETCH;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign alu_shifter_opcode = r_alu_op;
    assign c_select           = r_c_sel;
    assign b_select           = r_b_sel;
    assign busy               = (r_state != S_IDLE);
    assign done               = r_done;
    assign upc                = r_upc;

endmodule

`default_nettype wire

// File: tb/tb_micro_sequencer.sv
// ============================================================================
//  Module      : tb_micro_sequencer
//  Description : Directed self-checking bench for micro_sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_micro_sequencer;

    localparam int ADDR_W = 8;
    localparam int UW     = 24 + 2*ADDR_W;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic              ucode_we;
    logic [ADDR_W-1:0] ucode_addr;
    logic [UW-1:0]     ucode_wdata;
    logic              n;
    logic              z;
`ifdef SINGLE_STEP_EN
    logic              step;
`endif
    logic [7:0]        alu_shifter_opcode;
    logic [8:0]        c_select;
    logic [3:0]        b_select;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] upc;

    int n_checks = 0;
    int n_fails  = 0;

    micro_sequencer #(.ADDR_W(ADDR_W)) dut (
        .clock              (clock),
        .reset              (reset),
        .start              (start),
        .start_addr         (start_addr),
        .ucode_we           (ucode_we),
        .ucode_addr         (ucode_addr),
        .ucode_wdata        (ucode_wdata),
        .n                  (n),
        .z                  (z),
`ifdef SINGLE_STEP_EN
        .step               (step),
`endif
        .alu_shifter_opcode (alu_shifter_opcode),
        .c_select           (c_select),
        .b_select           (b_select),
        .busy               (busy),
        .done               (done),
        .upc                (upc)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [UW-1:0] mk(input logic [7:0] op, input logic [8:0] cs, input logic [3:0] bs,
                                         input logic [1:0] cond, input logic halt,
                                         input logic [7:0] nxt, input logic [7:0] br);
        return {br, nxt, halt, cond, bs, cs, op};
    endfunction

    task automatic load(input logic [7:0] addr, input logic [UW-1:0] word);
        ucode_we    = 1'b1;
        ucode_addr  = addr;
        ucode_wdata = word;
        tick();
        ucode_we    = 1'b0;
    endtask

    task automatic kick(input logic [7:0] addr);
        start      = 1'b1;
        start_addr = addr;
        tick();
        start      = 1'b0;
    endtask

    // addr 0 holds a branch word; addrs 5 and 9 hold distinct halt words.
    task automatic run_branch(input string tag, input logic [1:0] cond, input logic nv, input logic zv,
                              input logic [7:0] exp_upc, input logic [7:0] exp_op);
        load(8'd0, mk(8'h10, 9'h000, 4'h0, cond, 1'b0, 8'd5, 8'd9));
        n = nv;
        z = zv;
        kick(8'd0);
        tick();
        tick();
        check_eq({tag, "_upc"}, upc, exp_upc);
        check_eq({tag, "_fetch_csel"}, c_select, 0);
        tick();
        check_eq({tag, "_op"}, alu_shifter_opcode, exp_op);
        tick();
        check_eq({tag, "_done"}, done, 1);
        n = 1'b0;
        z = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start_addr = '0;
        ucode_we = 1'b0; ucode_addr = '0; ucode_wdata = '0;
        n = 1'b0; z = 1'b0;
`ifdef SINGLE_STEP_EN
        step = 1'b1;
`endif
        tick();
        tick();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_op", alu_shifter_opcode, 0);
        check_eq("rst_csel", c_select, 0);
        check_eq("rst_bsel", b_select, 0);
        check_eq("rst_upc", upc, 0);
        reset = 1'b0;
        tick();

        // Single halt word: controls after two edges, done on the third.
        load(8'd0, mk(8'h01, 9'h004, 4'h3, 2'b00, 1'b1, 8'd0, 8'd0));
        kick(8'd0);
        check_eq("fetch_busy", busy, 1);
        check_eq("fetch_csel", c_select, 0);
        tick();
        check_eq("exec_op", alu_shifter_opcode, 8'h01);
        check_eq("exec_csel", c_select, 9'h004);
        check_eq("exec_bsel", b_select, 4'h3);
        check_eq("exec_done", done, 0);
        tick();
        check_eq("halt_done", done, 1);
        check_eq("halt_busy", busy, 0);
        check_eq("halt_csel", c_select, 0);
        tick();
        check_eq("done_pulse", done, 0);

        load(8'd5, mk(8'h55, 9'h010, 4'h5, 2'b00, 1'b1, 8'd0, 8'd0));
        load(8'd9, mk(8'h99, 9'h100, 4'h9, 2'b00, 1'b1, 8'd0, 8'd0));

        // Nonzero start address goes straight to word 5.
        kick(8'd5);
        tick();
        check_eq("start5_op", alu_shifter_opcode, 8'h55);
        check_eq("start5_bsel", b_select, 4'h5);
        tick();
        check_eq("start5_done", done, 1);

        run_branch("jn_taken", 2'b01, 1'b1, 1'b0, 8'd9, 8'h99);
        run_branch("jn_seq",   2'b01, 1'b0, 1'b1, 8'd5, 8'h55);
        run_branch("jz_taken", 2'b10, 1'b0, 1'b1, 8'd9, 8'h99);
        run_branch("jz_seq",   2'b10, 1'b1, 1'b0, 8'd5, 8'h55);
        run_branch("jmp",      2'b11, 1'b0, 1'b0, 8'd9, 8'h99);
        run_branch("seq",      2'b00, 1'b1, 1'b1, 8'd5, 8'h55);

        // Writes while busy must not reach the running word.
        load(8'd0, mk(8'h01, 9'h004, 4'h3, 2'b00, 1'b1, 8'd0, 8'd0));
        kick(8'd0);
        ucode_we    = 1'b1;
        ucode_addr  = 8'd0;
        ucode_wdata = mk(8'hEE, 9'h1FF, 4'hF, 2'b00, 1'b1, 8'd0, 8'd0);
        tick();
        tick();
        ucode_we = 1'b0;
        check_eq("wbusy_done", done, 1);
        kick(8'd0);
        tick();
        check_eq("wbusy_op", alu_shifter_opcode, 8'h01);
        check_eq("wbusy_csel", c_select, 9'h004);
        tick();

        // Write and start in the same idle cycle: FETCH sees the new word.
        ucode_we    = 1'b1;
        ucode_addr  = 8'd0;
        ucode_wdata = mk(8'h77, 9'h002, 4'h7, 2'b00, 1'b1, 8'd0, 8'd0);
        start       = 1'b1;
        start_addr  = 8'd0;
        tick();
        ucode_we = 1'b0;
        start    = 1'b0;
        tick();
        check_eq("wstart_op", alu_shifter_opcode, 8'h77);
        tick();
        tick();

        // Reset in the middle of a self-looping word.
        load(8'd0, mk(8'h42, 9'h1FF, 4'h2, 2'b00, 1'b0, 8'd0, 8'd0));
        kick(8'd0);
        tick();
        check_eq("loop_csel", c_select, 9'h1FF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mrst_busy", busy, 0);
        check_eq("mrst_csel", c_select, 0);
        check_eq("mrst_upc", upc, 0);
        for (int i = 0; i < 4; i++) begin
            check_eq("mrst_nodone", done, 0);
            tick();
        end

`ifdef SINGLE_STEP_EN
        load(8'd0, mk(8'h42, 9'h001, 4'h2, 2'b00, 1'b0, 8'd5, 8'd0));
        step = 1'b0;
        kick(8'd0);
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        check_eq("hold_op", alu_shifter_opcode, 8'h42);
        check_eq("hold_upc", upc, 0);
        check_eq("hold_busy", busy, 1);
        step = 1'b1;
        tick();
        step = 1'b0;
        check_eq("step_upc", upc, 5);
        tick();
        tick();
        tick();
        check_eq("step_hold_op", alu_shifter_opcode, 8'h55);
        check_eq("step_hold_done", done, 0);
        step = 1'b1;
        tick();
        check_eq("step_done", done, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
